wbs_spi_master: RTL and testbench

//  Wishbone B4 pipelined slave that turns each local bus cycle into one SPI-master frame.

---
 rtl/wbs_spi_if.sv | 24 ++
 rtl/wbs_spi_master.sv | 248 ++++++++++++++++++++++++
 tb/tb_wbs_spi_master.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbs_spi_if.sv
// Wishbone B4 pipelined bus bundle between a local bus master and wbs_spi_master.
// A request transfers on a clock where wb_cyc_i & wb_stb_i & !wb_stall_o; wb_ack_o/wb_err_o are one-cycle completions.
interface wbs_spi_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [15:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_stall_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_stall_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_stall_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wbs_spi_master.sv
// Wishbone pipelined slave that turns each bus cycle into one SPI mode-0 frame (cmd, addr, data, ack-poll).
// Optional poll timeout with wb_err_o: define WBS_SPI_TIMEOUT_EN. BYTE_GAP must be >= 1.
module wbs_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int BYTE_GAP = 8,
  parameter int CS_GAP   = 2,
  parameter int MAX_POLL = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  wbs_spi_if.slave   wb,
  output logic       spi_sck,
  output logic       spi_csn,
  output logic       spi_sdo,
  input  logic       spi_sdi,
  output logic [3:0] dbg_state
);

  localparam int DMAX = (CLK_DIV > BYTE_GAP) ? CLK_DIV : BYTE_GAP;
  localparam int CW   = $clog2(DMAX + 1);
  localparam int GW   = $clog2(CS_GAP + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADR, S_WD0, S_WD1, S_WD2, S_WD3,
    S_POLL, S_RD0, S_RD1, S_RD2, S_RD3, S_END, S_GAP
  } state_t;

  typedef enum logic [1:0] {PH_LOW, PH_HIGH, PH_GAP} phase_t;

  state_t          state;
  phase_t          phase;
  logic [CW-1:0]   div_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      tx_sh;
  logic [7:0]      rx_sh;
  logic [23:0]     rd_word;
  logic            we_q;
  logic [3:0]      sel_q;
  logic [7:0]      adr_q;
  logic [31:0]     dat_q;
  logic            cyc_lost;
  logic            ack_q;
  logic            stall_q;
  logic [31:0]     dat_o_q;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      next_byte;

`ifdef WBS_SPI_TIMEOUT_EN
  localparam int PW = $clog2(MAX_POLL + 1);
  logic          err_q;
  logic [PW-1:0] poll_cnt;
  assign wb.wb_err_o = err_q;
`else
  assign wb.wb_err_o = 1'b0;
`endif

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_stall_o = stall_q;
  assign wb.wb_dat_o   = dat_o_q;
  assign dbg_state     = state;

  // Only address bits [9:2] travel over SPI.
  logic unused_adr;
  assign unused_adr = ^{wb.wb_adr_i[15:10], wb.wb_adr_i[1:0]};

  // Byte to shift out once the current byte (and its gap) has finished.
  always_comb begin
    next_byte = 8'h00;
    case (state)
      S_IDLE:  next_byte = {wb.wb_we_i, 3'b000, wb.wb_sel_i};
      S_CMD:   next_byte = adr_q;
      S_ADR:   next_byte = we_q ? dat_q[31:24] : 8'h00;
      S_WD0:   next_byte = dat_q[23:16];
      S_WD1:   next_byte = dat_q[15:8];
      S_WD2:   next_byte = dat_q[7:0];
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= S_IDLE;
      phase    <= PH_LOW;
      div_cnt  <= '0;
      bit_cnt  <= 3'd7;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      rd_word  <= 24'h0;
      we_q     <= 1'b0;
      sel_q    <= 4'h0;
      adr_q    <= 8'h00;
      dat_q    <= 32'h0;
      cyc_lost <= 1'b0;
      ack_q    <= 1'b0;
      stall_q  <= 1'b0;
      dat_o_q  <= 32'h0;
      gap_cnt  <= '0;
      spi_sck  <= 1'b0;
      spi_csn  <= 1'b1;
      spi_sdo  <= 1'b0;
`ifdef WBS_SPI_TIMEOUT_EN
      err_q    <= 1'b0;
      poll_cnt <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef WBS_SPI_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (wb.wb_cyc_i && wb.wb_stb_i) begin
            we_q     <= wb.wb_we_i;
            sel_q    <= wb.wb_sel_i;
            adr_q    <= wb.wb_adr_i[9:2];
            dat_q    <= wb.wb_dat_i;
            cyc_lost <= 1'b0;
            stall_q  <= 1'b1;
            spi_csn  <= 1'b0;
            tx_sh    <= next_byte;
            spi_sdo  <= next_byte[7];
            phase    <= PH_LOW;
            div_cnt  <= '0;
            bit_cnt  <= 3'd7;
`ifdef WBS_SPI_TIMEOUT_EN
            poll_cnt <= '0;
`endif
            state    <= S_CMD;
          end
        end

        S_END: begin
          if (CS_GAP == 0) begin
            stall_q <= 1'b0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt == GW'(CS_GAP - 1)) begin
            stall_q <= 1'b0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          // A dropped cycle still finishes the SPI frame, but its completion is swallowed.
          if (!wb.wb_cyc_i) cyc_lost <= 1'b1;
          case (phase)
            PH_LOW: begin
              if (div_cnt == CW'(CLK_DIV - 1)) begin
                div_cnt <= '0;
                spi_sck <= 1'b1;
                rx_sh   <= {rx_sh[6:0], spi_sdi};
                phase   <= PH_HIGH;
              end else begin
                div_cnt <= div_cnt + 1'b1;
              end
            end

            PH_HIGH: begin
              if (div_cnt == CW'(CLK_DIV - 1)) begin
                div_cnt <= '0;
                spi_sck <= 1'b0;
                if (bit_cnt == 3'd0) begin
                  phase <= PH_GAP;
                end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                  tx_sh   <= {tx_sh[6:0], 1'b0};
                  spi_sdo <= tx_sh[6];
                  phase   <= PH_LOW;
                end
              end else begin
                div_cnt <= div_cnt + 1'b1;
              end
            end

            default: begin
              if (div_cnt == CW'(BYTE_GAP - 1)) begin
                div_cnt <= '0;
                bit_cnt <= 3'd7;
                phase   <= PH_LOW;
                tx_sh   <= next_byte;
                spi_sdo <= next_byte[7];
                case (state)
                  S_CMD: state <= S_ADR;
                  S_ADR: state <= we_q ? S_WD0 : S_POLL;
                  S_WD0: state <= S_WD1;
                  S_WD1: state <= S_WD2;
                  S_WD2: state <= S_WD3;
                  S_WD3: state <= S_POLL;
                  S_POLL: begin
                    if (rx_sh == 8'h00) begin
                      if (we_q) begin
                        state   <= S_END;
                        spi_csn <= 1'b1;
                        ack_q   <= wb.wb_cyc_i & ~cyc_lost;
                      end else begin
                        state <= S_RD0;
                      end
                    end else begin
`ifdef WBS_SPI_TIMEOUT_EN
                      if (poll_cnt == PW'(MAX_POLL - 1)) begin
                        state   <= S_END;
                        spi_csn <= 1'b1;
                        err_q   <= wb.wb_cyc_i & ~cyc_lost;
                      end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                      end
`endif
                    end
                  end
                  S_RD0: begin
                    rd_word <= {rd_word[15:0], rx_sh};
                    state   <= S_RD1;
                  end
                  S_RD1: begin
                    rd_word <= {rd_word[15:0], rx_sh};
                    state   <= S_RD2;
                  end
                  S_RD2: begin
                    rd_word <= {rd_word[15:0], rx_sh};
                    state   <= S_RD3;
                  end
                  S_RD3: begin
                    dat_o_q <= {rd_word, rx_sh};
                    state   <= S_END;
                    spi_csn <= 1'b1;
                    ack_q   <= wb.wb_cyc_i & ~cyc_lost;
                  end
                  default: state <= S_IDLE;
                endcase
              end else begin
                div_cnt <= div_cnt + 1'b1;
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbs_spi_master.sv
// Randomized bench for wbs_spi_master: Wishbone driver, behavioural SPI slave, frame-level reference model.
// Define WBS_SPI_TIMEOUT_EN to also exercise the poll timeout (MAX_POLL=4).
module tb_wbs_spi_master;
  localparam int CLK_DIV  = 4;
  localparam int BYTE_GAP = 8;
  localparam int CS_GAP   = 2;
  localparam int T        = 10;
`ifdef WBS_SPI_TIMEOUT_EN
  localparam int MAX_POLL = 4;
`else
  localparam int MAX_POLL = 255;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #(T/2) clk = ~clk;

  wbs_spi_if bus();
  logic       spi_sck, spi_csn, spi_sdo;
  logic       spi_sdi = 1'b0;
  logic [3:0] dbg_state;

  wbs_spi_master #(
    .CLK_DIV(CLK_DIV), .BYTE_GAP(BYTE_GAP), .CS_GAP(CS_GAP), .MAX_POLL(MAX_POLL)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb       (bus),
    .spi_sck  (spi_sck),
    .spi_csn  (spi_csn),
    .spi_sdo  (spi_sdo),
    .spi_sdi  (spi_sdi),
    .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // ---------------- behavioural SPI slave ----------------
  logic [7:0] miso_q[$];
  logic [7:0] mosi_cap[$];
  logic [7:0] exp_q[$];
  logic [7:0] cur = 8'h00;
  int         bitpos = 0;
  bit         cur_valid = 0;
  bit         first_rise = 0;
  logic       sck_prev = 1'b0;
  logic [7:0] mosi_sh = 8'h00;
  int         mosi_bits = 0;
  int         frame_bytes = 0;
  int         last_frame_bytes = 0;
  int         timing_err = 0;
  int         sdo_err = 0;
  time        t_fall = 0, t_rise_sck = 0, t_sdo = 0;
  time        t_fall_q[$];
  time        t_rise_q[$];

  function automatic logic peek_bit();
    return (miso_q.size() != 0) ? miso_q[0][7] : 1'b0;
  endfunction

  always @(spi_sdo) t_sdo = $time;

  always @(posedge spi_sck or negedge spi_sck or negedge spi_csn) begin
    if (spi_sck !== sck_prev) begin
      sck_prev = spi_sck;
      if (spi_sck === 1'b1) begin
        if (first_rise) begin
          if ($time - t_fall != CLK_DIV*T) timing_err++;
        end else if (mosi_bits != 0) begin
          if ($time - t_rise_sck != 2*CLK_DIV*T) timing_err++;
        end else if ($time - t_rise_sck != (2*CLK_DIV+BYTE_GAP)*T) begin
          timing_err++;
        end
        if ($time - t_sdo < CLK_DIV*T) sdo_err++;
        first_rise = 0;
        t_rise_sck = $time;
        if (!cur_valid) begin
          cur = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
          cur_valid = 1;
          bitpos = 7;
        end
        mosi_sh = {mosi_sh[6:0], spi_sdo};
        mosi_bits++;
        if (mosi_bits == 8) begin
          mosi_cap.push_back(mosi_sh);
          frame_bytes++;
          mosi_bits = 0;
        end
      end else begin
        if (cur_valid && bitpos > 0) begin
          bitpos--;
          spi_sdi = cur[bitpos];
        end else begin
          cur_valid = 0;
          spi_sdi = peek_bit();
        end
      end
    end else if (spi_csn === 1'b0) begin
      cur_valid = 0;
      mosi_bits = 0;
      frame_bytes = 0;
      first_rise = 1;
      t_fall = $time;
      t_fall_q.push_back($time);
      spi_sdi = peek_bit();
    end
  end

  always @(posedge spi_csn) begin
    t_rise_q.push_back($time);
    last_frame_bytes = frame_bytes;
  end

  // ---------------- completion monitor ----------------
  int          ack_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] ack_dat = 32'h0;
  time         t_ack = 0;
  always @(negedge clk) begin
    if (bus.wb_ack_o === 1'b1) begin
      ack_cnt++;
      ack_dat = bus.wb_dat_o;
      t_ack = $time;
    end
    if (bus.wb_err_o === 1'b1) err_cnt++;
  end

  // ---------------- reference model ----------------
  logic [31:0] model_dat = 32'h0;

  task automatic model_frame(input logic we, input logic [3:0] sel, input logic [15:0] adr,
                             input logic [31:0] dat, input int nwait, input logic [31:0] rdat);
    logic [7:0] b;
    exp_q.push_back({we, 3'b000, sel});
    exp_q.push_back(8'((adr >> 2) & 16'h00FF));
    miso_q.push_back(8'($urandom));
    miso_q.push_back(8'($urandom));
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        b = 8'(dat >> (8*(3-i)));
        exp_q.push_back(b);
        miso_q.push_back(8'($urandom));
      end
    end
    for (int i = 0; i < nwait; i++) begin
      exp_q.push_back(8'h00);
      miso_q.push_back(8'($urandom_range(1, 255)));
    end
    exp_q.push_back(8'h00);
    miso_q.push_back(8'h00);
    if (!we) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(8'h00);
        miso_q.push_back(8'(rdat >> (8*(3-i))));
      end
    end
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_nbytes"}, mosi_cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < mosi_cap.size()) check({tag, "_mosi"}, mosi_cap[i], exp_q[i]);
    end
  endtask

  task automatic clear_frame();
    mosi_cap.delete();
    exp_q.delete();
    t_fall_q.delete();
    t_rise_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  time t_acc = 0;

  task automatic wb_req(input logic we, input logic [3:0] sel, input logic [15:0] adr,
                        input logic [31:0] dat);
    int n = 0;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    while (bus.wb_stall_o !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) check("req_accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    bus.wb_stb_i = 1'b0;
    t_acc = $time;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while ((ack_cnt + err_cnt) < target && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) check({tag, "_done_timeout"}, 32'(ack_cnt + err_cnt), 32'(target));
  endtask

  task automatic run_txn(input logic we, input logic [3:0] sel, input logic [15:0] adr,
                         input logic [31:0] dat, input int nwait, input logic [31:0] rdat,
                         input string tag);
    int a0, e0, te0, se0;
    logic [31:0] want_dat;
    clear_frame();
    a0 = ack_cnt; e0 = err_cnt; te0 = timing_err; se0 = sdo_err;
    model_frame(we, sel, adr, dat, nwait, rdat);
    want_dat = we ? model_dat : rdat;
    model_dat = want_dat;
    wb_req(we, sel, adr, dat);
    wait_done(a0 + e0 + 1, tag);
    @(negedge clk);
    bus.wb_cyc_i = 1'b0;
    check({tag, "_ack"}, 32'(ack_cnt - a0), 32'd1);
    check({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
    check({tag, "_dat"}, ack_dat, want_dat);
    check({tag, "_csn_bytes"}, 32'(last_frame_bytes), 32'(exp_q.size()));
    check_bytes(tag);
    check({tag, "_sck_timing"}, 32'(timing_err - te0), 32'd0);
    check({tag, "_sdo_setup"}, 32'(sdo_err - se0), 32'd0);
    repeat (CS_GAP + 3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, n;
    logic ok;
    time t_acc_a, t_ack_a;
    logic [31:0] rd;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'h0;
    bus.wb_adr_i = 16'h0;
    bus.wb_dat_i = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_csn",   spi_csn,         1);
    check("rst_sck",   spi_sck,         0);
    check("rst_sdo",   spi_sdo,         0);
    check("rst_ack",   bus.wb_ack_o,    0);
    check("rst_err",   bus.wb_err_o,    0);
    check("rst_stall", bus.wb_stall_o,  0);
    check("rst_dat",   bus.wb_dat_o,    0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed write and read frames
    run_txn(1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, 2, 32'h0, "wr_dir");
    run_txn(1'b0, 4'h3, 16'h03FC, 32'h0, 1, 32'h12345678, "rd_dir");

    // Randomized frames
    for (int i = 0; i < 6; i++) begin
      run_txn(1'($urandom), 4'($urandom), 16'($urandom), $urandom,
              $urandom_range(0, 3), $urandom, "rand");
    end

    // Second request issued while the first frame is busy
    clear_frame();
    a0 = ack_cnt;
    rd = $urandom;
    model_frame(1'b1, 4'h5, 16'h0124, 32'hCAFEF00D, 1, 32'h0);
    model_frame(1'b0, 4'hA, 16'h0200, 32'h0, 0, rd);
    wb_req(1'b1, 4'h5, 16'h0124, 32'hCAFEF00D);
    t_acc_a = t_acc;
    wb_req(1'b0, 4'hA, 16'h0200, 32'h0);
    wait_done(a0 + err_cnt + 2, "b2b");
    @(negedge clk);
    bus.wb_cyc_i = 1'b0;
    model_dat = rd;
    t_ack_a = 0;
    check("b2b_acks", 32'(ack_cnt - a0), 32'd2);
    check("b2b_rd_dat", ack_dat, rd);
    check_bytes("b2b");
    ok = (t_rise_q.size() >= 1) && (t_fall_q.size() >= 2) && (t_acc > t_acc_a)
         && (t_acc > t_rise_q[0]) && (t_fall_q[1] - t_rise_q[0] >= CS_GAP*T);
    check("b2b_stall_held", 32'(ok), 32'd1);
    repeat (CS_GAP + 3) @(negedge clk);

    // Cycle dropped mid-frame: frame completes, no ack
    clear_frame();
    a0 = ack_cnt;
    model_frame(1'b1, 4'hC, 16'h0088, 32'h0BADF00D, 1, 32'h0);
    wb_req(1'b1, 4'hC, 16'h0088, 32'h0BADF00D);
    @(negedge clk);
    bus.wb_cyc_i = 1'b0;
    n = 0;
    while (t_rise_q.size() == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (CS_GAP + 4) @(negedge clk);
    check("drop_no_ack", 32'(ack_cnt - a0), 32'd0);
    check_bytes("drop");

    // Reset asserted in WD1, then a clean frame
    clear_frame();
    a0 = ack_cnt;
    model_frame(1'b1, 4'hF, 16'h0040, 32'h11223344, 0, 32'h0);
    wb_req(1'b1, 4'hF, 16'h0040, 32'h11223344);
    n = 0;
    while (frame_bytes < 3 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reach_wd1", 32'(frame_bytes), 32'd3);
    repeat (BYTE_GAP + 2*CLK_DIV + 2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_csn",   spi_csn,        1);
    check("rst_mid_sck",   spi_sck,        0);
    check("rst_mid_stall", bus.wb_stall_o, 0);
    check("rst_mid_dat",   bus.wb_dat_o,   0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    miso_q.delete();
    model_dat = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_mid_no_ack", 32'(ack_cnt - a0), 32'd0);
    run_txn(1'b0, 4'h1, 16'h0104, 32'h0, 1, 32'hA5A55A5A, "post_rst");

`ifdef WBS_SPI_TIMEOUT_EN
    // Every poll returns a wait value: MAX_POLL polls then err
    clear_frame();
    a0 = ack_cnt;
    n = err_cnt;
    miso_q.delete();
    for (int i = 0; i < 20; i++) miso_q.push_back(8'hFF);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h10);
    for (int i = 0; i < MAX_POLL; i++) exp_q.push_back(8'h00);
    wb_req(1'b0, 4'h2, 16'h0040, 32'h0);
    wait_done(a0 + n + 1, "tmo");
    repeat (2) @(negedge clk);
    bus.wb_cyc_i = 1'b0;
    check("tmo_err", 32'(err_cnt - n), 32'd1);
    check("tmo_no_ack", 32'(ack_cnt - a0), 32'd0);
    check("tmo_dat_kept", bus.wb_dat_o, model_dat);
    check("tmo_csn_bytes", 32'(last_frame_bytes), 32'(exp_q.size()));
    check_bytes("tmo");
    miso_q.delete();
    repeat (CS_GAP + 3) @(negedge clk);
`else
    check("err_never", 32'(err_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
